// File: rtl/control_sequencer.sv
// Control sequencer: six T-state fetch/execute ring with single-instruction
// stepping and a terminal halt; control strobes are decoded from the current state.
module control_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] ir_op,
  input  logic       step_en,
  input  logic       step,
  output logic       cp,
  output logic       ep,
  output logic       lm,
  output logic       epr,
  output logic       li,
  output logic       ei,
  output logic       la,
  output logic       ea,
  output logic       su,
  output logic       eu,
  output logic       lb,
  output logic       lo,
  output logic       hlt,
  output logic [5:0] t_state
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T1   = 4'd1,
    S_T2   = 4'd2,
    S_T3   = 4'd3,
    S_T4   = 4'd4,
    S_T5   = 4'd5,
    S_T6   = 4'd6,
    S_WAIT = 4'd7,
    S_HALT = 4'd8
  } state_t;

  typedef struct packed {
    logic cp;
    logic ep;
    logic lm;
    logic epr;
    logic li;
    logic ei;
    logic la;
    logic ea;
    logic su;
    logic eu;
    logic lb;
    logic lo;
  } ctrl_t;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_LDB = 4'b0111;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  state_t state_r;
  ctrl_t  ctrl_s;
  logic   hlt_s;
  logic [5:0] t_state_s;

  // Fetch strobes are identical for every opcode.
  function automatic ctrl_t fetch_ctrl(input state_t st);
    ctrl_t c;
    c = '0;
    case (st)
      S_T1: begin
        c.ep = 1'b1;
        c.lm = 1'b1;
      end
      S_T2: c.cp = 1'b1;
      S_T3: begin
        c.epr = 1'b1;
        c.li  = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic ctrl_t exec_ctrl(input logic [3:0] op, input state_t st);
    ctrl_t c;
    c = '0;
    case (st)
      S_T4: begin
        case (op)
          OP_LDA, OP_ADD, OP_SUB, OP_LDB: begin
            c.ei = 1'b1;
            c.lm = 1'b1;
          end
          OP_OUT: begin
            c.ea = 1'b1;
            c.lo = 1'b1;
          end
          default: c = '0;
        endcase
      end
      S_T5: begin
        case (op)
          OP_LDA: begin
            c.epr = 1'b1;
            c.la  = 1'b1;
          end
          OP_ADD, OP_SUB, OP_LDB: begin
            c.epr = 1'b1;
            c.lb  = 1'b1;
          end
          default: c = '0;
        endcase
      end
      S_T6: begin
        case (op)
          OP_ADD: begin
            c.la = 1'b1;
            c.eu = 1'b1;
          end
          OP_SUB: begin
            c.la = 1'b1;
            c.eu = 1'b1;
            c.su = 1'b1;
          end
          default: c = '0;
        endcase
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // State register; HLT is resolved at T4 so T5/T6 never run for it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      case (state_r)
        S_IDLE: state_r <= S_T1;
        S_T1:   state_r <= S_T2;
        S_T2:   state_r <= S_T3;
        S_T3:   state_r <= S_T4;
        S_T4:   state_r <= (ir_op == OP_HLT) ? S_HALT : S_T5;
        S_T5:   state_r <= S_T6;
        S_T6:   state_r <= step_en ? S_WAIT : S_T1;
        S_WAIT: state_r <= step ? S_T1 : S_WAIT;
        S_HALT: state_r <= S_HALT;
        default: state_r <= S_IDLE;
      endcase
    end
  end

  // Strobe decode from current state and opcode.
  always_comb begin
    ctrl_s = '0;
    if ((state_r == S_T1) || (state_r == S_T2) || (state_r == S_T3)) begin
      ctrl_s = fetch_ctrl(state_r);
    end else if ((state_r == S_T4) || (state_r == S_T5) || (state_r == S_T6)) begin
      ctrl_s = exec_ctrl(ir_op, state_r);
    end else begin
      ctrl_s = '0;
    end
  end

  // One-hot T-state view and halt flag.
  always_comb begin
    t_state_s = 6'b000000;
    hlt_s     = 1'b0;
    case (state_r)
      S_T1:   t_state_s = 6'b000001;
      S_T2:   t_state_s = 6'b000010;
      S_T3:   t_state_s = 6'b000100;
      S_T4:   t_state_s = 6'b001000;
      S_T5:   t_state_s = 6'b010000;
      S_T6:   t_state_s = 6'b100000;
      S_HALT: hlt_s     = 1'b1;
      default: begin
        t_state_s = 6'b000000;
        hlt_s     = 1'b0;
      end
    endcase
  end

  assign {cp, ep, lm, epr, li, ei, la, ea, su, eu, lb, lo} = ctrl_s;
  assign hlt     = hlt_s;
  assign t_state = t_state_s;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: fixed vector table, directed corner sequences
// and randomized traffic against a microcode-table reference model.
module tb_control_sequencer;

  logic       clk;
  logic       rst_n;
  logic [3:0] ir_op;
  logic       step_en;
  logic       step;
  logic cp, ep, lm, epr, li, ei, la, ea, su, eu, lb, lo, hlt;
  logic [5:0] t_state;

  control_sequencer dut (
    .clk(clk), .rst_n(rst_n), .ir_op(ir_op), .step_en(step_en), .step(step),
    .cp(cp), .ep(ep), .lm(lm), .epr(epr), .li(li), .ei(ei), .la(la), .ea(ea),
    .su(su), .eu(eu), .lb(lb), .lo(lo), .hlt(hlt), .t_state(t_state)
  );

  localparam logic [11:0] CP  = 12'h800, EP = 12'h400, LM = 12'h200, EPR = 12'h100;
  localparam logic [11:0] LI  = 12'h080, EI = 12'h040, LA = 12'h020, EA  = 12'h010;
  localparam logic [11:0] SU  = 12'h008, EU = 12'h004, LB = 12'h002, LO  = 12'h001;

  wire [11:0] ctrl = {cp, ep, lm, epr, li, ei, la, ea, su, eu, lb, lo};
  wire [4:0]  bus  = {ep, epr, ei, ea, eu};

  typedef struct {
    logic [3:0]  op;
    logic [11:0] ctrl;
    logic [5:0]  ts;
  } vec_t;

  int passed = 0;
  int total  = 0;

  // Reference model: mode 0 idle, 1 running T-step m_t, 2 waiting, 3 halted
  int m_mode;
  int m_t;
  logic [11:0] micro [16][7];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    else
      passed++;
  endtask

  task automatic build_micro();
    for (int op = 0; op < 16; op++) begin
      for (int t = 0; t < 7; t++) micro[op][t] = 12'h000;
      micro[op][1] = EP | LM;
      micro[op][2] = CP;
      micro[op][3] = EPR | LI;
    end
    micro[0][4]  = EI | LM;  micro[0][5]  = EPR | LA;
    micro[3][4]  = EI | LM;  micro[3][5]  = EPR | LB;  micro[3][6] = LA | EU;
    micro[6][4]  = EI | LM;  micro[6][5]  = EPR | LB;  micro[6][6] = LA | EU | SU;
    micro[7][4]  = EI | LM;  micro[7][5]  = EPR | LB;
    micro[14][4] = EA | LO;
  endtask

  task automatic model_compare(input string tag);
    logic [11:0] e_ctrl;
    logic [5:0]  e_ts;
    if (!rst_n) m_mode = 0;
    e_ctrl = (m_mode == 1) ? micro[ir_op][m_t] : 12'h000;
    e_ts   = (m_mode == 1) ? (6'b000001 << (m_t - 1)) : 6'b000000;
    chk({tag, "_ctrl"}, {20'd0, ctrl}, {20'd0, e_ctrl});
    chk({tag, "_hlt"}, {31'd0, hlt}, {31'd0, (m_mode == 3)});
    chk({tag, "_tstate"}, {26'd0, t_state}, {26'd0, e_ts});
    chk({tag, "_bus_excl"}, {31'd0, ($countones(bus) <= 1)}, 32'd1);
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      m_mode = 0;
    end else if (m_mode == 0) begin
      m_mode = 1; m_t = 1;
    end else if (m_mode == 1) begin
      if (m_t == 4 && ir_op == 4'd15) m_mode = 3;
      else if (m_t < 6) m_t = m_t + 1;
      else if (step_en) m_mode = 2;
      else m_t = 1;
    end else if (m_mode == 2) begin
      if (step) begin m_mode = 1; m_t = 1; end
    end
  endtask

  task automatic step_cycle(input string tag);
    #1;
    model_compare(tag);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Asserts reset, holds it across two edges, releases after an edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_compare("reset");
    repeat (2) begin
      @(posedge clk);
      model_edge();
      #1;
    end
    rst_n = 1'b1;
  endtask

  vec_t vecs [37];
  int t1cnt;

  initial begin
    rst_n = 1'b0; ir_op = 4'd0; step_en = 1'b0; step = 1'b0;
    m_mode = 0; m_t = 1;
    build_micro();

    vecs[0]  = '{4'd0,  12'h000,       6'd0};
    vecs[1]  = '{4'd0,  EP | LM,       6'd1};
    vecs[2]  = '{4'd0,  CP,            6'd2};
    vecs[3]  = '{4'd0,  EPR | LI,      6'd4};
    vecs[4]  = '{4'd0,  EI | LM,       6'd8};
    vecs[5]  = '{4'd0,  EPR | LA,      6'd16};
    vecs[6]  = '{4'd0,  12'h000,       6'd32};
    vecs[7]  = '{4'd3,  EP | LM,       6'd1};
    vecs[8]  = '{4'd3,  CP,            6'd2};
    vecs[9]  = '{4'd3,  EPR | LI,      6'd4};
    vecs[10] = '{4'd3,  EI | LM,       6'd8};
    vecs[11] = '{4'd3,  EPR | LB,      6'd16};
    vecs[12] = '{4'd3,  LA | EU,       6'd32};
    vecs[13] = '{4'd6,  EP | LM,       6'd1};
    vecs[14] = '{4'd6,  CP,            6'd2};
    vecs[15] = '{4'd6,  EPR | LI,      6'd4};
    vecs[16] = '{4'd6,  EI | LM,       6'd8};
    vecs[17] = '{4'd6,  EPR | LB,      6'd16};
    vecs[18] = '{4'd6,  LA | EU | SU,  6'd32};
    vecs[19] = '{4'd7,  EP | LM,       6'd1};
    vecs[20] = '{4'd7,  CP,            6'd2};
    vecs[21] = '{4'd7,  EPR | LI,      6'd4};
    vecs[22] = '{4'd7,  EI | LM,       6'd8};
    vecs[23] = '{4'd7,  EPR | LB,      6'd16};
    vecs[24] = '{4'd7,  12'h000,       6'd32};
    vecs[25] = '{4'd5,  EP | LM,       6'd1};
    vecs[26] = '{4'd5,  CP,            6'd2};
    vecs[27] = '{4'd5,  EPR | LI,      6'd4};
    vecs[28] = '{4'd5,  12'h000,       6'd8};
    vecs[29] = '{4'd5,  12'h000,       6'd16};
    vecs[30] = '{4'd5,  12'h000,       6'd32};
    vecs[31] = '{4'd14, EP | LM,       6'd1};
    vecs[32] = '{4'd14, CP,            6'd2};
    vecs[33] = '{4'd14, EPR | LI,      6'd4};
    vecs[34] = '{4'd14, EA | LO,       6'd8};
    vecs[35] = '{4'd14, 12'h000,       6'd16};
    vecs[36] = '{4'd14, 12'h000,       6'd32};

    // Table: LDA, ADD, SUB, LDB, NOP, OUT back to back from reset
    do_reset();
    for (int i = 0; i < 37; i++) begin
      ir_op = vecs[i].op;
      #1;
      chk($sformatf("vec%0d_ctrl", i), {20'd0, ctrl}, {20'd0, vecs[i].ctrl});
      chk($sformatf("vec%0d_tstate", i), {26'd0, t_state}, {26'd0, vecs[i].ts});
      chk($sformatf("vec%0d_hlt", i), {31'd0, hlt}, 32'd0);
      @(posedge clk);
      model_edge();
      #1;
    end

    // HLT: terminal until reset, step/step_en ignored
    ir_op = 4'd15;
    do_reset();
    for (int k = 0; k < 10 && !hlt; k++) step_cycle("hlt_run");
    chk("hlt_reached", {31'd0, hlt}, 32'd1);
    for (int k = 0; k < 22; k++) begin
      step = k[0];
      step_en = 1'($urandom_range(0, 1));
      step_cycle("hlt_hold");
    end
    step = 1'b0; step_en = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("hlt_async_clear", {31'd0, hlt}, 32'd0);
    chk("hlt_async_tstate", {26'd0, t_state}, 32'd0);

    // OUT in single-instruction mode, then a 3-cycle step pulse
    ir_op = 4'd14;
    step_en = 1'b1;
    do_reset();
    for (int k = 0; k < 12 && !(m_mode == 2); k++) step_cycle("out_run");
    chk("wait_reached", {26'd0, t_state}, 32'd0);
    for (int k = 0; k < 10; k++) step_cycle("wait_hold");
    t1cnt = 0;
    for (int k = 0; k < 14; k++) begin
      step = (k < 3);
      #1;
      if (t_state == 6'b000001) t1cnt++;
      model_compare("step_pass");
      @(posedge clk);
      model_edge();
      #1;
    end
    step = 1'b0;
    chk("one_pass_per_step", t1cnt, 32'd1);
    chk("back_in_wait_ctrl", {20'd0, ctrl}, 32'd0);

    // Async reset during T5 of ADD
    ir_op = 4'd3;
    step_en = 1'b0;
    do_reset();
    for (int k = 0; k < 10 && !(m_mode == 1 && m_t == 5); k++) step_cycle("add_run");
    #1;
    chk("add_t5_lb", {31'd0, lb}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("add_async_lb", {31'd0, lb}, 32'd0);
    chk("add_async_tstate", {26'd0, t_state}, 32'd0);
    do_reset();
    step_cycle("post_rst_idle");
    step_cycle("post_rst_t1");

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      ir_op = 4'($urandom_range(0, 15));
      if (ir_op == 4'd15 && $urandom_range(0, 3) != 0) ir_op = 4'd5;
      if ($urandom_range(0, 7) == 0) step_en = ~step_en;
      step = ($urandom_range(0, 3) == 0);
      rst_n = ($urandom_range(0, 99) != 0);
      if (m_mode == 3 && $urandom_range(0, 9) == 0) rst_n = 1'b0;
      step_cycle("rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
